// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one fetch in flight, buffers PC-tagged words for decode.
// Optional build macro PC_FETCH_MISALIGN_TRAP_EN adds misalign_err and a HALT state for bad redirect targets.
module pc_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            redir_src,
    input  logic [DATA_WIDTH-1:0] redir_pc,
    input  logic [DATA_WIDTH-1:0] redir_imm,
    input  logic [DATA_WIDTH-1:0] redir_alu,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    output logic                  misalign_err,
`endif
    output logic [DATA_WIDTH-1:0] fetch_pc
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] req_pc;
    logic                  outstanding;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc   [BUF_DEPTH];

    logic                  redirect;
    logic [DATA_WIDTH-1:0] raw_target;
    logic [DATA_WIDTH-1:0] target;
    logic [CNT_W:0]        inflight;
    logic                  handshake;
    logic                  push;
    logic                  pop;

    assign redirect = (redir_src == 2'b01) || (redir_src == 2'b10);

    always_comb begin
        raw_target = redir_pc + redir_imm;
        if (redir_src == 2'b10)
            raw_target = {redir_alu[DATA_WIDTH-1:1], 1'b0};
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = redirect && raw_target[1];
    assign target   = raw_target;
`else
    assign target   = raw_target & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
`endif

    // Issue only while the FIFO is guaranteed room for the reply; this is what makes a full push impossible.
    assign inflight       = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    assign imem_req_valid = (state == S_REQ) && (inflight < (CNT_W+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign handshake      = imem_req_valid && imem_req_ready;

    assign push       = (state == S_WAIT) && imem_rsp_valid && !redirect;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = buf_data[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (handshake) begin
                        req_pc      <= fetch_pc;
                        outstanding <= 1'b1;
                    end
                    if (redirect) begin
                        fetch_pc <= target;
                        if (handshake)
                            state <= S_DRAIN;
                    end else if (handshake) begin
                        fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= S_REQ;
                    end else if (redirect) begin
                        state <= S_DRAIN;
                    end
                    if (redirect)
                        fetch_pc <= target;
                end
                // The wrong-path reply is swallowed here; a redirect arriving meanwhile only retargets.
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        outstanding <= 1'b0;
                        state       <= S_REQ;
                    end
                    if (redirect)
                        fetch_pc <= target;
                end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_IDLE;
            endcase
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (misalign && state != S_IDLE && state != S_HALT) begin
                state        <= S_HALT;
                outstanding  <= 1'b0;
                misalign_err <= 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= imem_rsp_data;
                buf_pc[wr_ptr]   <= req_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with a one-outstanding instruction memory model.
// Build with PC_FETCH_MISALIGN_TRAP_EN defined to exercise the misalign trap instead of the aligned fallback.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  redir_src;
    logic [31:0] redir_pc;
    logic [31:0] redir_imm;
    logic [31:0] redir_alu;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetch_pc;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int          assert_count = 0;
    int          fail_count   = 0;

    logic        pending;
    logic [31:0] paddr;
    int          wcnt;
    int          mem_lat;
    logic [31:0] hs_log [$];
    logic [31:0] del_pc [$];
    logic [31:0] del_data [$];

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redir_src      (redir_src),
        .redir_pc       (redir_pc),
        .redir_imm      (redir_imm),
        .redir_alu      (redir_alu),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        .misalign_err   (misalign_err),
`endif
        .fetch_pc       (fetch_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    function automatic logic [31:0] hs_at(input int i);
        return (i < hs_log.size()) ? hs_log[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] del_pc_at(input int i);
        return (i < del_pc.size()) ? del_pc[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] del_data_at(input int i);
        return (i < del_data.size()) ? del_data[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: record what fires at the coming edge, then advance the memory model just after it.
    task automatic applyStimulus();
        logic        hs;
        logic        rsp_fired;
        logic [31:0] a;
        #1;
        hs        = imem_req_valid && imem_req_ready;
        a         = imem_req_addr;
        rsp_fired = imem_rsp_valid;
        if (inst_valid && inst_ready) begin
            del_pc.push_back(inst_pc);
            del_data.push_back(inst_data);
        end
        @(posedge clk);
        #1;
        redir_src = 2'b00;
        if (rsp_fired)
            pending = 1'b0;
        if (hs) begin
            pending = 1'b1;
            paddr   = a;
            wcnt    = mem_lat - 1;
            hs_log.push_back(a);
        end else if (pending && wcnt > 0) begin
            wcnt--;
        end
        imem_rsp_valid = pending && (wcnt == 0);
        imem_rsp_data  = pending ? mem_word(paddr) : 32'h0;
    endtask

    task automatic applyReset();
        rst_n          = 1'b0;
        redir_src      = 2'b00;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        pending        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hs_log.delete();
        del_pc.delete();
        del_data.delete();
    endtask

    task automatic runUntilHs(input int n, input int budget, input string tag);
        int k = 0;
        while (hs_log.size() < n && k < budget) begin
            applyStimulus();
            k++;
        end
        checkOutput(tag, 32'(hs_log.size()), 32'(n));
    endtask

    initial begin
        rst_n          = 1'b0;
        redir_src      = 2'b00;
        redir_pc       = 32'h0;
        redir_imm      = 32'h0;
        redir_alu      = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b1;
        pending        = 1'b0;
        paddr          = 32'h0;
        wcnt           = 0;
        mem_lat        = 1;

        #2;
        checkOutput("rst req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst inst_data", inst_data, 32'h0);
        checkOutput("rst inst_pc", inst_pc, 32'h0);
        checkOutput("rst fetch_pc", fetch_pc, 32'h0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        checkOutput("rst misalign_err", 32'(misalign_err), 32'h0);
`endif

        // Sequential fetch with zero-wait memory
        applyReset();
        applyStimulus();
        checkOutput("seq first req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("seq first addr", imem_req_addr, 32'h0);
        runUntilHs(3, 20, "seq hs count");
        checkOutput("seq fetch_pc after 3", fetch_pc, 32'hC);
        repeat (4) applyStimulus();
        checkOutput("seq hs0", hs_at(0), 32'h0);
        checkOutput("seq hs1", hs_at(1), 32'h4);
        checkOutput("seq hs2", hs_at(2), 32'h8);
        checkOutput("seq pc0", del_pc_at(0), 32'h0);
        checkOutput("seq pc1", del_pc_at(1), 32'h4);
        checkOutput("seq pc2", del_pc_at(2), 32'h8);
        checkOutput("seq data0", del_data_at(0), 32'hC0DE_0000);
        checkOutput("seq data2", del_data_at(2), 32'hC0DE_0008);

        // Decode stall fills the buffer and blocks issue
        applyReset();
        inst_ready = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("stall hs count", 32'(hs_log.size()), 32'd2);
        checkOutput("stall req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("stall inst_valid", 32'(inst_valid), 32'h1);
        checkOutput("stall head pc", inst_pc, 32'h0);
        checkOutput("stall delivered", 32'(del_pc.size()), 32'd0);
        inst_ready = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("stall drain pc0", del_pc_at(0), 32'h0);
        checkOutput("stall drain pc1", del_pc_at(1), 32'h4);
        checkOutput("stall drain data1", del_data_at(1), 32'hC0DE_0004);

        // Branch redirect while waiting on a slow response
        applyReset();
        mem_lat = 2;
        applyStimulus();
        runUntilHs(1, 5, "br hs count");
        redir_src = 2'b01;
        redir_pc  = 32'h100;
        redir_imm = 32'h20;
        applyStimulus();
        checkOutput("br fetch_pc", fetch_pc, 32'h120);
        checkOutput("br inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("br drain req_valid", 32'(imem_req_valid), 32'h0);
        applyStimulus();
        checkOutput("br req_valid", 32'(imem_req_valid), 32'h1);
        checkOutput("br req_addr", imem_req_addr, 32'h120);
        checkOutput("br dropped", 32'(inst_valid), 32'h0);
        repeat (6) applyStimulus();
        checkOutput("br hs1", hs_at(1), 32'h120);
        checkOutput("br del pc", del_pc_at(0), 32'h120);
        checkOutput("br del data", del_data_at(0), 32'hC0DE_0120);

        // JALR redirect while the request is stalled
        applyReset();
        mem_lat        = 1;
        imem_req_ready = 1'b0;
        applyStimulus();
        checkOutput("jalr pre addr", imem_req_addr, 32'h0);
        redir_src = 2'b10;
        redir_alu = 32'h2001;
        applyStimulus();
        checkOutput("jalr addr", imem_req_addr, 32'h2000);
        checkOutput("jalr req_valid", 32'(imem_req_valid), 32'h1);
        imem_req_ready = 1'b1;
        repeat (5) applyStimulus();
        checkOutput("jalr hs0", hs_at(0), 32'h2000);
        checkOutput("jalr del pc", del_pc_at(0), 32'h2000);

        // Redirect coinciding with a response and a pop
        applyReset();
        inst_ready = 1'b0;
        applyStimulus();
        runUntilHs(2, 10, "coinc hs count");
        inst_ready = 1'b1;
        redir_src  = 2'b01;
        redir_pc   = 32'h40;
        redir_imm  = 32'hFFFF_FFF8;
        applyStimulus();
        del_pc.delete();
        del_data.delete();
        checkOutput("coinc inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("coinc fetch_pc", fetch_pc, 32'h38);
        checkOutput("coinc req_addr", imem_req_addr, 32'h38);
        repeat (5) applyStimulus();
        checkOutput("coinc del pc", del_pc_at(0), 32'h38);
        checkOutput("coinc del data", del_data_at(0), 32'hC0DE_0038);

        // Asynchronous reset mid-WAIT, then a late response while idle
        applyReset();
        inst_ready = 1'b0;
        applyStimulus();
        runUntilHs(2, 10, "arst hs count");
        rst_n = 1'b0;
        #1;
        checkOutput("arst inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("arst inst_data", inst_data, 32'h0);
        checkOutput("arst fetch_pc", fetch_pc, 32'h0);
        checkOutput("arst req_valid", 32'(imem_req_valid), 32'h0);
        applyStimulus();
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        del_pc.delete();
        del_data.delete();
        hs_log.delete();
        applyStimulus();
        checkOutput("arst late rsp ignored", 32'(inst_valid), 32'h0);
        checkOutput("arst first addr", imem_req_addr, 32'h0);
        checkOutput("arst req_valid after", 32'(imem_req_valid), 32'h1);
        inst_ready = 1'b1;
        repeat (5) applyStimulus();
        checkOutput("arst del pc", del_pc_at(0), 32'h0);
        checkOutput("arst del data", del_data_at(0), 32'hC0DE_0000);

        // JALR to a half-word-aligned target
        applyReset();
        imem_req_ready = 1'b0;
        applyStimulus();
        redir_src = 2'b10;
        redir_alu = 32'h2002;
        applyStimulus();
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        checkOutput("mis err", 32'(misalign_err), 32'h1);
        checkOutput("mis req_valid", 32'(imem_req_valid), 32'h0);
        imem_req_ready = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("mis halted req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("mis halted hs", 32'(hs_log.size()), 32'd0);
        checkOutput("mis err sticky", 32'(misalign_err), 32'h1);
`else
        checkOutput("mis aligned addr", imem_req_addr, 32'h2000);
        checkOutput("mis req_valid", 32'(imem_req_valid), 32'h1);
        imem_req_ready = 1'b1;
        repeat (4) applyStimulus();
        checkOutput("mis hs0", hs_at(0), 32'h2000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
